// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Round-robin sharing of one fixed-latency memory between the
//           instruction-fetch port and the load/store data port.
// Rev     : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,

  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,

  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int         BE_W  = DATA_WIDTH / 8;
  localparam logic [3:0] c_LAT = 4'(MEM_LATENCY);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_lat_cnt;
  logic       r_owner_d;
  logic       r_last_d;

  logic w_final;
  logic w_can_grant;
  logic w_gnt_i;
  logic w_gnt_d;

  // The final BUSY cycle both retires the current access and may accept the next.
  assign w_final     = (r_state == S_BUSY) && (r_lat_cnt == 4'd1);
  assign w_can_grant = rst && ((r_state == S_IDLE) || w_final);

  // On conflict the port that was not served last wins.
  assign w_gnt_d = w_can_grant && d_req && (!i_req || !r_last_d);
  assign w_gnt_i = w_can_grant && i_req && !w_gnt_d;

  assign i_gnt    = w_gnt_i;
  assign d_gnt    = w_gnt_d;
  assign i_rvalid = rst && w_final && !r_owner_d;
  assign d_rvalid = rst && w_final &&  r_owner_d;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  assign mem_en    = w_gnt_i || w_gnt_d;
  assign mem_we    = w_gnt_d && d_we;
  assign mem_addr  = w_gnt_d ? d_addr  : (w_gnt_i ? i_addr : '0);
  assign mem_wdata = w_gnt_d ? d_wdata : '0;
  assign mem_be    = w_gnt_d ? d_be    : (w_gnt_i ? {BE_W{1'b1}} : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= 4'd0;
      r_owner_d <= 1'b0;
      r_last_d  <= 1'b0;
    end else if (w_gnt_i || w_gnt_d) begin
      r_state   <= S_BUSY;
      r_lat_cnt <= c_LAT;
      r_owner_d <= w_gnt_d;
      r_last_d  <= w_gnt_d;
    end else if (r_state == S_BUSY) begin
      r_lat_cnt <= r_lat_cnt - 4'd1;
      if (w_final) begin
        r_state <= S_IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Self-checking bench for mem_port_arbiter at latencies 2 and 1.
// Rev     : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic        s_ireq   [2];
  logic [31:0] s_iaddr  [2];
  logic        s_dreq   [2];
  logic        s_dwe    [2];
  logic [31:0] s_daddr  [2];
  logic [31:0] s_dwdata [2];
  logic [3:0]  s_dbe    [2];
  logic [31:0] s_mrdata [2];

  logic        o_ig  [2];
  logic        o_iv  [2];
  logic [31:0] o_ird [2];
  logic        o_dg  [2];
  logic        o_dv  [2];
  logic [31:0] o_drd [2];
  logic        o_men [2];
  logic        o_mwe [2];
  logic [31:0] o_maddr [2];
  logic [31:0] o_mwd   [2];
  logic [3:0]  o_mbe   [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_LATENCY((k == 0) ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (s_ireq[k]),
      .i_addr   (s_iaddr[k]),
      .i_gnt    (o_ig[k]),
      .i_rvalid (o_iv[k]),
      .i_rdata  (o_ird[k]),
      .d_req    (s_dreq[k]),
      .d_we     (s_dwe[k]),
      .d_addr   (s_daddr[k]),
      .d_wdata  (s_dwdata[k]),
      .d_be     (s_dbe[k]),
      .d_gnt    (o_dg[k]),
      .d_rvalid (o_dv[k]),
      .d_rdata  (o_drd[k]),
      .mem_en   (o_men[k]),
      .mem_we   (o_mwe[k]),
      .mem_addr (o_maddr[k]),
      .mem_wdata(o_mwd[k]),
      .mem_be   (o_mbe[k]),
      .mem_rdata(s_mrdata[k])
    );
  end

  always #5 clk = ~clk;

  // Memory emulation (reacts to the DUT) and reference memory (follows the model).
  logic [31:0] emu_mem [2][64];
  logic [31:0] ref_mem [2][64];
  int          rd_due  [2];
  logic [31:0] rd_val  [2];

  bit          m_pend  [2];
  int          m_due   [2];
  bit          m_own_d [2];
  bit          m_last_d[2];
  bit          m_we    [2];
  logic [31:0] m_data  [2];

  bit lg_i [2];
  bit lg_d [2];
  int wait_i [2];
  int wait_d [2];
  int gcount [2];
  int cyc;
  int n_chk = 0;
  int n_pass = 0;

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic eval(int k);
    bit resp, free, gi, gd, iv, dv;
    logic [31:0] ea, ird, drd;
    logic [3:0]  ebe;
    int L;
    L = lat_of(k);
    if (!rst) begin
      check_eq($sformatf("rst_ctl%0d", k),
               {o_ig[k], o_dg[k], o_iv[k], o_dv[k], o_men[k], o_mwe[k], o_mbe[k]}, 64'd0);
      check_eq($sformatf("rst_data%0d", k),
               {o_ird[k] | o_drd[k], o_maddr[k] | o_mwd[k]}, 64'd0);
      m_pend[k] = 0; m_last_d[k] = 0; rd_due[k] = -1;
      wait_i[k] = 0; wait_d[k] = 0; lg_i[k] = 0; lg_d[k] = 0;
      return;
    end
    resp = m_pend[k] && (m_due[k] == cyc);
    free = !m_pend[k] || resp;
    gi = 0; gd = 0;
    if (free) begin
      if (s_ireq[k] && s_dreq[k]) begin
        if (m_last_d[k]) gi = 1; else gd = 1;
      end else begin
        gi = s_ireq[k];
        gd = s_dreq[k];
      end
    end
    iv  = resp && !m_own_d[k];
    dv  = resp &&  m_own_d[k];
    ird = iv ? m_data[k] : 32'd0;
    drd = dv ? m_data[k] : 32'd0;
    ea  = gd ? s_daddr[k] : (gi ? s_iaddr[k] : 32'd0);
    ebe = gd ? s_dbe[k] : (gi ? 4'hF : 4'h0);

    check_eq($sformatf("ctl%0d", k),
             {o_ig[k], o_dg[k], o_iv[k], o_dv[k], o_men[k], o_mwe[k], o_mbe[k]},
             {gi, gd, iv, dv, gi | gd, gd & s_dwe[k], ebe});
    check_eq($sformatf("maddr%0d", k), {o_maddr[k], o_mwd[k]},
             {ea, gd ? s_dwdata[k] : 32'd0});
    check_eq($sformatf("i_rdata%0d", k), o_ird[k], ird);
    if (!(dv && m_we[k])) check_eq($sformatf("d_rdata%0d", k), o_drd[k], drd);

    if (o_ig[k]) check_eq($sformatf("starve_i%0d", k), wait_i[k] <= 2 * L, 1);
    if (o_dg[k]) check_eq($sformatf("starve_d%0d", k), wait_d[k] <= 2 * L, 1);
    wait_i[k] = (s_ireq[k] && !o_ig[k]) ? wait_i[k] + 1 : 0;
    wait_d[k] = (s_dreq[k] && !o_dg[k]) ? wait_d[k] + 1 : 0;
    lg_i[k] = o_ig[k];
    lg_d[k] = o_dg[k];
    if (o_ig[k] || o_dg[k]) gcount[k]++;

    if (resp) m_pend[k] = 0;
    if (gi || gd) begin
      m_pend[k]   = 1;
      m_due[k]    = cyc + L;
      m_own_d[k]  = gd;
      m_last_d[k] = gd;
      m_we[k]     = gd && s_dwe[k];
      if (m_we[k]) ref_mem[k][ea[7:2]] = merge(ref_mem[k][ea[7:2]], s_dwdata[k], s_dbe[k]);
      else         m_data[k] = ref_mem[k][ea[7:2]];
    end

    if (o_men[k]) begin
      if (o_mwe[k]) emu_mem[k][o_maddr[k][7:2]] = merge(emu_mem[k][o_maddr[k][7:2]], o_mwd[k], o_mbe[k]);
      else begin
        rd_due[k] = cyc + L;
        rd_val[k] = emu_mem[k][o_maddr[k][7:2]];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) s_mrdata[k] = (rd_due[k] == cyc) ? rd_val[k] : $urandom;
    #1;
    for (int k = 0; k < 2; k++) eval(k);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(bit ir, logic [31:0] ia, bit dr, bit dwe, logic [31:0] da,
                       logic [31:0] wd, logic [3:0] be);
    for (int k = 0; k < 2; k++) begin
      s_ireq[k] = ir; s_iaddr[k] = ia;
      s_dreq[k] = dr; s_dwe[k] = dwe; s_daddr[k] = da; s_dwdata[k] = wd; s_dbe[k] = be;
    end
  endtask

  task automatic idle(int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_stim(int k);
    if (!s_ireq[k] || lg_i[k]) begin
      s_ireq[k]  = ($urandom % 3) != 0;
      s_iaddr[k] = 32'($urandom_range(0, 1023)) << 2;
    end else if (($urandom % 16) == 0) s_ireq[k] = 0;
    if (!s_dreq[k] || lg_d[k]) begin
      s_dreq[k]   = ($urandom % 3) != 0;
      s_dwe[k]    = $urandom % 2;
      s_daddr[k]  = 32'($urandom_range(0, 1023)) << 2;
      s_dwdata[k] = $urandom;
      s_dbe[k]    = 4'($urandom);
    end else if (($urandom % 16) == 0) s_dreq[k] = 0;
  endtask

  initial begin
    logic [31:0] v;
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      rd_due[k] = -1; m_pend[k] = 0; m_last_d[k] = 0; gcount[k] = 0;
      wait_i[k] = 0; wait_d[k] = 0; s_mrdata[k] = 0;
      for (int a = 0; a < 64; a++) begin
        v = (a == 0) ? 32'h0050_0093 : $urandom;
        emu_mem[k][a] = v;
        ref_mem[k][a] = v;
      end
    end
    rst = 1'b0;
    drive(1, 32'h100, 1, 1, 32'h40, 32'h1234, 4'hF);
    step(); step();
    rst = 1'b1;

    // Single fetch, then conflict (D wins the first conflict), then a store.
    drive(1, 32'h100, 0, 0, 0, 0, 0);                step();
    idle(3);
    drive(1, 32'h200, 1, 0, 32'h1000, 0, 0);         step();
    drive(1, 32'h200, 0, 0, 0, 0, 0);                step(); step();
    idle(3);
    drive(0, 0, 1, 1, 32'h2004, 32'hDEAD_BEEF, 4'b0011); step();
    idle(3);
    drive(0, 0, 1, 0, 32'h2004, 0, 0);               step();
    idle(3);

    // Both ports requesting continuously.
    gcount[0] = 0; gcount[1] = 0;
    drive(1, 32'h300, 1, 0, 32'h1008, 0, 0);
    for (int i = 0; i < 20; i++) step();
    check_eq("fair_cnt0", gcount[0], 10);
    check_eq("fair_cnt1", gcount[1], 20);
    idle(3);

    // Reset one cycle after a data grant; a fresh fetch follows release.
    drive(0, 0, 1, 0, 32'h1010, 0, 0);               step();
    drive(1, 32'h340, 0, 0, 0, 0, 0);
    rst = 1'b0;                                      step();
    rst = 1'b1;                                      step();
    idle(3);

    // Back-to-back fetches.
    drive(1, 32'h104, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    idle(3);

    // Randomized traffic with per-port hold-until-granted requesters.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) rand_stim(k);
      step();
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
